// File: rtl/adc_scan_ctrl_if.sv
// SPI transaction handshake between the scan sequencer (master side)
// and the 24-bit spi_master core (slave side).
interface adc_scan_ctrl_if;
    logic        spi_start;
    logic [23:0] spi_data_in;
    logic        spi_done;
    logic [23:0] spi_data_out;

    modport master (
        output spi_start,
        output spi_data_in,
        input  spi_done,
        input  spi_data_out
    );

    modport slave (
        input  spi_start,
        input  spi_data_in,
        output spi_done,
        output spi_data_out
    );
endinterface

// File: rtl/adc_scan_ctrl.sv
// Periodic multi-channel scan sequencer for an MCP3008-class ADC behind a
// 24-bit mode-0 spi_master; emits one sample pulse per channel per frame.
module adc_scan_ctrl #(
    parameter int  F_SAMPLE = 10_000,
    parameter int  N_CH     = 4,
    parameter int  TIMEOUT  = 4096,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   clr_err,
    adc_scan_ctrl_if.master        spi,
    output logic                   sample_valid,
    output logic [CH_W-1:0]        sample_ch,
    output logic [9:0]             sample_data,
    output logic                   frame_done,
    output logic                   busy,
    output logic                   overrun,
    output logic                   spi_err
);
    localparam int F_CLK        = 100_000_000;
    localparam int SAMPLE_TICKS = F_CLK / F_SAMPLE;
    localparam int TCNT_W       = $clog2(SAMPLE_TICKS);
    localparam int WCNT_W       = $clog2(TIMEOUT + 1);

    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(SAMPLE_TICKS - 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(N_CH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] NEXT  = 2'd3;

    logic [1:0]        state;
    logic [TCNT_W-1:0] tcnt;
    logic [WCNT_W-1:0] wcnt;
    logic [CH_W-1:0]   ch;
    logic              tick;
    logic              ovr_set;
    logic              err_set;

    // Start bit, single-ended mode, 3-bit channel select, MSb first.
    function automatic logic [23:0] cmd_frame(input logic [CH_W-1:0] c);
        logic [2:0] c3;
        c3 = 3'(c);
        return {8'h01, 1'b1, c3, 4'h0, 8'h00};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
        end else if (!en || tcnt == TCNT_LAST) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    always_comb begin
        tick    = en && (tcnt == TCNT_LAST);
        ovr_set = tick && (state != IDLE);
        err_set = (state == WAIT) && !spi.spi_done && (wcnt == WCNT_LAST);
        busy    = (state != IDLE);
    end

    // Start and data_in are registered on entry to ISSUE so both are valid
    // for exactly the ISSUE cycle; data_in then holds until the next issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            ch              <= '0;
            wcnt            <= '0;
            spi.spi_start   <= 1'b0;
            spi.spi_data_in <= '0;
            sample_valid    <= 1'b0;
            sample_ch       <= '0;
            sample_data     <= '0;
            frame_done      <= 1'b0;
        end else begin
            spi.spi_start <= 1'b0;
            sample_valid  <= 1'b0;
            frame_done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        ch              <= '0;
                        spi.spi_start   <= 1'b1;
                        spi.spi_data_in <= cmd_frame('0);
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    wcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    wcnt <= wcnt + 1'b1;
                    if (spi.spi_done) begin
                        sample_valid <= 1'b1;
                        sample_ch    <= ch;
                        sample_data  <= spi.spi_data_out[9:0];
                        frame_done   <= (ch == CH_LAST);
                        state        <= NEXT;
                    end else if (wcnt == WCNT_LAST) begin
                        state <= IDLE;
                    end
                end
                NEXT: begin
                    if (ch == CH_LAST) begin
                        state <= IDLE;
                    end else begin
                        ch              <= ch + 1'b1;
                        spi.spi_start   <= 1'b1;
                        spi.spi_data_in <= cmd_frame(ch + 1'b1);
                        state           <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as a clear takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
            spi_err <= 1'b0;
        end else begin
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
            if (err_set) begin
                spi_err <= 1'b1;
            end else if (clr_err) begin
                spi_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Bench for adc_scan_ctrl: randomized SPI slave delays/data against a
// timeline model of frames, plus a short-timeout instance for error paths.
module tb_adc_scan_ctrl;
    localparam int PERIOD = 100;
    localparam int NCH    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en_a, clr_a, en_b, clr_b;
    logic       sv_a, fd_a, busy_a, ovr_a, err_a;
    logic [0:0] sch_a;
    logic [9:0] sdat_a;
    logic       sv_b, fd_b, busy_b, ovr_b, err_b;
    logic [0:0] sch_b;
    logic [9:0] sdat_b;

    adc_scan_ctrl_if if_a ();
    adc_scan_ctrl_if if_b ();

    adc_scan_ctrl #(.F_SAMPLE(1_000_000), .N_CH(NCH), .TIMEOUT(4096)) u_a (
        .clk(clk), .rst(rst), .en(en_a), .clr_err(clr_a), .spi(if_a),
        .sample_valid(sv_a), .sample_ch(sch_a), .sample_data(sdat_a),
        .frame_done(fd_a), .busy(busy_a), .overrun(ovr_a), .spi_err(err_a)
    );

    adc_scan_ctrl #(.F_SAMPLE(1_000_000), .N_CH(NCH), .TIMEOUT(16)) u_b (
        .clk(clk), .rst(rst), .en(en_b), .clr_err(clr_b), .spi(if_b),
        .sample_valid(sv_b), .sample_ch(sch_b), .sample_data(sdat_b),
        .frame_done(fd_b), .busy(busy_b), .overrun(ovr_b), .spi_err(err_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Per-transaction slave behaviour, indexed by transaction number.
    int          dly [0:15];
    logic [23:0] rsp [0:15];
    int          sk;
    int          pend;
    logic [23:0] pend_dat;

    initial begin
        if_a.spi_done     = 1'b0;
        if_a.spi_data_out = '0;
        pend              = 0;
        sk                = 0;
        forever begin
            @(posedge clk); #1;
            if_a.spi_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    if_a.spi_done     = 1'b1;
                    if_a.spi_data_out = pend_dat;
                end
            end
            if (if_a.spi_start === 1'b1 && sk < 16) begin
                pend     = dly[sk];
                pend_dat = rsp[sk];
                sk++;
            end
        end
    end

    initial begin
        if_b.spi_done     = 1'b0;
        if_b.spi_data_out = 24'($urandom());
    end

    int          st_cyc[$];
    logic [23:0] st_dat[$];
    int          sv_cyc[$];
    int          sv_ch[$];
    int          sv_dat[$];
    int          fd_cyc[$];
    int          stb_cyc[$];
    logic [23:0] stb_dat[$];
    int          svb_n = 0;
    int          fdb_n = 0;
    logic        prev_start_a = 1'b0;
    logic        prev_start_b = 1'b0;

    always @(negedge clk) begin
        if (if_a.spi_start === 1'b1) begin
            check("a_start_b2b", 32'(prev_start_a), 32'd0);
            st_cyc.push_back(cyc);
            st_dat.push_back(if_a.spi_data_in);
        end
        prev_start_a = if_a.spi_start;
        if (sv_a === 1'b1) begin
            sv_cyc.push_back(cyc);
            sv_ch.push_back(int'(sch_a));
            sv_dat.push_back(int'(sdat_a));
        end
        if (fd_a === 1'b1) fd_cyc.push_back(cyc);
        if (if_b.spi_start === 1'b1) begin
            check("b_start_b2b", 32'(prev_start_b), 32'd0);
            stb_cyc.push_back(cyc);
            stb_dat.push_back(if_b.spi_data_in);
        end
        prev_start_b = if_b.spi_start;
        if (sv_b === 1'b1) svb_n++;
        if (fd_b === 1'b1) fdb_n++;
    end

    int ex_st_cyc[$];
    int ex_st_dat[$];
    int ex_sv_cyc[$];
    int ex_sv_ch[$];
    int ex_sv_dat[$];
    int ex_fd_cyc[$];
    int ex_ovr;

    // Frame timeline: ticks every PERIOD while enabled; each channel takes
    // start -> done after its delay -> sample next cycle -> next start.
    task automatic predict(input int e, input int stop);
        int t, s, v, k, nt;
        ex_st_cyc.delete(); ex_st_dat.delete();
        ex_sv_cyc.delete(); ex_sv_ch.delete(); ex_sv_dat.delete();
        ex_fd_cyc.delete();
        ex_ovr = 0;
        k = 0;
        v = 0;
        t = e + PERIOD - 1;
        while (t < stop) begin
            s = t + 1;
            for (int c = 0; c < NCH; c++) begin
                ex_st_cyc.push_back(s);
                ex_st_dat.push_back(32'h018000 + (c << 12));
                v = s + dly[k] + 1;
                ex_sv_cyc.push_back(v);
                ex_sv_ch.push_back(c);
                ex_sv_dat.push_back(int'(rsp[k]) % 1024);
                k++;
                s = v + 1;
            end
            ex_fd_cyc.push_back(v);
            nt = t + PERIOD;
            while (nt <= v) begin
                if (nt < stop) ex_ovr = 1;
                nt += PERIOD;
            end
            t = nt;
        end
    endtask

    task automatic compare_a(input string tag);
        check({tag, "_nstart"}, st_cyc.size(), ex_st_cyc.size());
        for (int i = 0; i < st_cyc.size() && i < ex_st_cyc.size(); i++) begin
            check($sformatf("%s_st%0d_cyc", tag, i), st_cyc[i], ex_st_cyc[i]);
            check($sformatf("%s_st%0d_dat", tag, i), 32'(st_dat[i]), ex_st_dat[i]);
        end
        check({tag, "_nsample"}, sv_cyc.size(), ex_sv_cyc.size());
        for (int i = 0; i < sv_cyc.size() && i < ex_sv_cyc.size(); i++) begin
            check($sformatf("%s_sv%0d_cyc", tag, i), sv_cyc[i], ex_sv_cyc[i]);
            check($sformatf("%s_sv%0d_ch", tag, i), sv_ch[i], ex_sv_ch[i]);
            check($sformatf("%s_sv%0d_dat", tag, i), sv_dat[i], ex_sv_dat[i]);
        end
        check({tag, "_nframe"}, fd_cyc.size(), ex_fd_cyc.size());
        for (int i = 0; i < fd_cyc.size() && i < ex_fd_cyc.size(); i++) begin
            check($sformatf("%s_fd%0d_cyc", tag, i), fd_cyc[i], ex_fd_cyc[i]);
        end
    endtask

    task automatic clear_mon();
        st_cyc.delete(); st_dat.delete();
        sv_cyc.delete(); sv_ch.delete(); sv_dat.delete();
        fd_cyc.delete();
    endtask

    task automatic check_zero(input string tag, input logic st, input logic [23:0] di,
                              input logic sv, input logic [0:0] sc, input logic [9:0] sd,
                              input logic fd, input logic bs, input logic ov, input logic er);
        check({tag, "_start"}, 32'(st), 32'd0);
        check({tag, "_data_in"}, 32'(di), 32'd0);
        check({tag, "_valid"}, 32'(sv), 32'd0);
        check({tag, "_ch"}, 32'(sc), 32'd0);
        check({tag, "_data"}, 32'(sd), 32'd0);
        check({tag, "_frame"}, 32'(fd), 32'd0);
        check({tag, "_busy"}, 32'(bs), 32'd0);
        check({tag, "_overrun"}, 32'(ov), 32'd0);
        check({tag, "_err"}, 32'(er), 32'd0);
    endtask

    task automatic goto(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    int e;
    int stop;

    initial begin
        rst = 1'b0; en_a = 1'b0; clr_a = 1'b0; en_b = 1'b0; clr_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            dly[i] = 0;
            rsp[i] = '0;
        end
        #1 rst = 1'b1;
        goto(3);
        check_zero("rst_a", if_a.spi_start, if_a.spi_data_in, sv_a, sch_a, sdat_a,
                   fd_a, busy_a, ovr_a, err_a);
        check_zero("rst_b", if_b.spi_start, if_b.spi_data_in, sv_b, sch_b, sdat_b,
                   fd_b, busy_b, ovr_b, err_b);
        rst = 1'b0;

        // Enable held low, then nominal scans with random delays/data, en dropped mid-frame.
        clear_mon();
        goto(cyc + 500);
        check("gate_no_start", st_cyc.size(), 0);
        dly[0] = 20; rsp[0] = 24'h0002A5;
        dly[1] = 20; rsp[1] = 24'h0001FF;
        for (int i = 2; i < 16; i++) begin
            dly[i] = int'($urandom_range(40, 1));
            rsp[i] = 24'($urandom());
        end
        sk = 0;
        e = cyc + 1;
        goto(e);
        en_a = 1'b1;
        stop = e + 405;
        goto(stop);
        en_a = 1'b0;
        goto(e + 600);
        predict(e, stop);
        compare_a("nom");
        check("nom_overrun", 32'(ovr_a), ex_ovr);

        // Overrun: long slave latency makes the second tick land mid-frame.
        rst = 1'b1;
        goto(cyc + 1);
        rst = 1'b0;
        clear_mon();
        for (int i = 0; i < 16; i++) begin
            dly[i] = 80;
            rsp[i] = 24'($urandom());
        end
        sk = 0;
        e = cyc + 2;
        goto(e);
        en_a = 1'b1;
        goto(e + 199);
        check("ovr_before", 32'(ovr_a), 32'd0);
        goto(e + 200);
        check("ovr_set", 32'(ovr_a), 32'd1);
        stop = e + 560;
        goto(stop);
        en_a = 1'b0;
        goto(e + 760);
        predict(e, stop);
        compare_a("ovr");
        check("ovr_sticky", 32'(ovr_a), ex_ovr);
        clr_a = 1'b1;
        goto(cyc + 1);
        clr_a = 1'b0;
        check("ovr_clr", 32'(ovr_a), 32'd0);

        // Asynchronous reset mid-WAIT; the slave's late done must be ignored.
        clear_mon();
        dly[0] = 30;
        rsp[0] = 24'($urandom());
        sk = 0;
        e = cyc + 2;
        goto(e);
        en_a = 1'b1;
        goto(e + 106);
        check("arst_pre_busy", 32'(busy_a), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_zero("arst", if_a.spi_start, if_a.spi_data_in, sv_a, sch_a, sdat_a,
                   fd_a, busy_a, ovr_a, err_a);
        en_a = 1'b0;
        goto(e + 108);
        rst = 1'b0;
        goto(e + 180);
        check("arst_late_valid", sv_cyc.size(), 0);
        check("arst_busy", 32'(busy_a), 32'd0);
        check("arst_nstart", st_cyc.size(), 1);

        // Timeout instance: slave never answers.
        e = cyc + 2;
        goto(e);
        en_b = 1'b1;
        goto(e + 116);
        check("to_wait16_busy", 32'(busy_b), 32'd1);
        check("to_wait16_err", 32'(err_b), 32'd0);
        goto(e + 117);
        check("to_err", 32'(err_b), 32'd1);
        check("to_idle", 32'(busy_b), 32'd0);
        goto(e + 150);
        clr_b = 1'b1;
        goto(e + 151);
        clr_b = 1'b0;
        check("to_clr", 32'(err_b), 32'd0);
        goto(e + 216);
        clr_b = 1'b1;
        goto(e + 217);
        clr_b = 1'b0;
        check("to_collide", 32'(err_b), 32'd1);
        check("to_idle2", 32'(busy_b), 32'd0);
        goto(e + 230);
        en_b = 1'b0;
        check("to_nstart", stb_cyc.size(), 2);
        if (stb_cyc.size() >= 2) begin
            check("to_st0_cyc", stb_cyc[0], e + 100);
            check("to_st0_dat", 32'(stb_dat[0]), 32'h018000);
            check("to_st1_cyc", stb_cyc[1], e + 200);
            check("to_st1_dat", 32'(stb_dat[1]), 32'h018000);
        end
        check("to_no_valid", svb_n, 0);
        check("to_no_frame", fdb_n, 0);
        check("to_overrun", 32'(ovr_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_scan_ctrl.md
# adc_scan_ctrl

Periodic multi-channel ADC scan sequencer that drives an `spi_master` instance configured for N=24, mode 0. It operates the 10-bit, 8-channel MCP3008-class converter that digitises the echo microphones. On every sample tick it runs one 24-bit SPI transaction per enabled channel, in ascending order, and extracts the 10-bit result. Each sample is presented downstream as a one-cycle `sample_valid` pulse. The block also watches for sample-rate overruns and for SPI transactions that never complete.

## Interface
- `F_SAMPLE`, 10_000: frame rate in Hz. Localparam `F_CLK` = 100_000_000; `SAMPLE_TICKS` = `F_CLK/F_SAMPLE`, which must be ≥ 2.
- `N_CH`, 4: channels scanned per frame, 1..8. Localparam `CH_W` = max(1, `$clog2(N_CH)`).
- `TIMEOUT`, 4096: maximum number of WAIT cycles allowed for one transaction.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: scan enable.
- `clr_err` in 1: clears the sticky flags `overrun` and `spi_err`.
- `spi_start` out 1: one-cycle start pulse to `spi_master`.
- `spi_data_in` out 24: command frame.
- `spi_done` in 1: transaction-complete pulse from `spi_master`.
- `spi_data_out` in 24: received frame.
- `sample_valid` out 1: one-cycle pulse, qualifies `sample_ch`/`sample_data`.
- `sample_ch` out `CH_W`: channel of the current sample.
- `sample_data` out 10: conversion result.
- `frame_done` out 1: one-cycle pulse after the last channel of a frame.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `overrun` out 1: sticky; a sample tick arrived while busy.
- `spi_err` out 1: sticky; a transaction timed out.

## Operation
- **Tick counter** `tcnt`:
  - While `en`=0 it is held at 0.
  - While `en`=1 it counts 0..`SAMPLE_TICKS`-1 and wraps.
  - `tick` = `en` && `tcnt`==`SAMPLE_TICKS`-1 (combinational).
- **Command frame** for channel c: `{8'h01, 1'b1, c[2:0], 4'h0, 8'h00}` (start bit, single-ended mode, MSb first).
- **Result:** `spi_data_out[9:0]`.
- **FSM states:**
  - IDLE: on `tick`, set `ch`=0 and go to ISSUE.
  - ISSUE: `spi_start`=1 for exactly this cycle; `spi_data_in` carries the frame for `ch`. Clear `wcnt`; go to WAIT.
  - WAIT: `wcnt` increments each cycle.
    - On `spi_done`: capture the result and go to NEXT.
    - If `spi_done` is still absent when `wcnt`==`TIMEOUT`-1: set `spi_err` and go to IDLE. The frame is abandoned, with no `sample_valid` for that channel and no `frame_done`.
  - NEXT: registered `sample_valid`=1 with `sample_ch`=`ch` and `sample_data`=captured result.
    - If `ch`==`N_CH`-1: `frame_done`=1, go to IDLE.
    - Otherwise: `ch`+1, go to ISSUE.
- **Overrun:** `tick` seen while the state ≠ IDLE sets `overrun`. That tick is dropped; the current frame is not restarted.
- **Enable drop mid-frame:** `en` falling during a frame does not abort it; the frame completes normally.
- **Error clear and set together:** if `clr_err` and a set condition occur in the same cycle, the set wins.
- **`spi_data_in` outside ISSUE:** holds its last value; the slave only samples it on `spi_start`.
- **Reset values:** every output is 0, including `spi_data_in`, `sample_ch`, `sample_data`, `overrun` and `spi_err`. Internally, state = IDLE and `tcnt`=`ch`=`wcnt`=0.
- **Reset mid-operation:** everything returns to its reset value immediately (asynchronously). Any `spi_done` that arrives afterwards while in IDLE is ignored.

## Timing
- Tick at cycle T: ISSUE occurs at T+1, so `spi_start` is high at T+1.
- `spi_done` at cycle D: NEXT at D+1, so `sample_valid` is high at D+1.
- Next ISSUE is at D+2. This guarantees `spi_master` has been back in IDLE for at least one cycle before the next `spi_start`.
- `frame_done` coincides with the last channel's `sample_valid`.
- `busy` is high from T+1 through the NEXT cycle of the last channel, inclusive.
- First tick after `en` rises at cycle E occurs at cycle E+`SAMPLE_TICKS`-1 (`tcnt` starts at 0 at E).
- `spi_start` is never asserted in two consecutive cycles.

## Test plan
- **Nominal scan.** Configure `F_SAMPLE`=1_000_000 (100-clk period) and `N_CH`=2. Slave model returns done 20 cycles after start with `data_out`=24'h0002A5 (ch0) and 24'h0001FF (ch1). Required response:
  - `spi_data_in` = 24'h018000, then 24'h019000.
  - `sample_valid` pulses give (0, 10'h2A5) and (1, 10'h1FF).
  - `frame_done` pulses on the second sample.
  - Next `spi_start` is exactly 100 cycles after the first.
- **Overrun.** Slave delays done by 80 cycles, `N_CH`=2. Required response: `overrun`=1 at the second tick; that frame completes its 2 samples with no restart; `clr_err` pulse → `overrun`=0.
- **Timeout.** Set `TIMEOUT`=16; slave never asserts done. Required response: `spi_err`=1 on the 16th WAIT cycle; `busy`=0 on the following cycle; no `sample_valid`; next tick reissues ch0.
- **Enable gating.** Hold `en`=0 for 500 cycles → no `spi_start`. Raise `en` at cycle E → first `spi_start` at E+100. Drop `en` mid-frame → remaining samples and `frame_done` are still produced, then no further starts.
- **Async reset mid-WAIT.** Assert `rst` between clock edges → all outputs 0 immediately. Late `spi_done` after release produces no `sample_valid`.
- **Set/clear collision.** Drive `clr_err` high in the same cycle the timeout fires → `spi_err` reads 1 afterwards.
